// File: rtl/uart_pkg.sv
// Purpose: types and constants shared by the UART receiver and transmitter.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
//
// Contents: uart_state_t, uart_rx_res_t, DATA_BITS, OVS_DEFAULT, counter
// widths, and helpers that turn an oversampling ratio into tick thresholds.
package uart_pkg;

  localparam int DATA_BITS   = 8;
  localparam int OVS_DEFAULT = 16;
  localparam int TICK_CNT_W  = 4;
  localparam int BIT_CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Result of one received frame, kept together so data and status
  // always update on the same edge.
  typedef struct packed {
    logic                 frame_err;
    logic [DATA_BITS-1:0] data;
  } uart_rx_res_t;

  // Tick index at the middle of a bit, counted from the detected edge.
  function automatic logic [TICK_CNT_W-1:0] tick_mid(input int ovs);
    return TICK_CNT_W'(ovs / 2 - 1);
  endfunction

  // Last tick index of a full bit period.
  function automatic logic [TICK_CNT_W-1:0] tick_end(input int ovs);
    return TICK_CNT_W'(ovs - 1);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Purpose: multi-flop synchronizer that brings the async serial line into clk.
// Latency: STAGES clks from i_d to o_q.
// Backpressure: none; the output follows the input every clock.
//
// Ports:
//   i_clk   - system clock
//   i_rst_n - async active-low reset; all flops reset to 1 (line idle level)
//   i_d     - asynchronous input
//   o_q     - synchronized output
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver driven by a shared OVS-times-baud tick strobe.
// Latency: o_rx_done rises 1 clk after the mid-stop-bit b_tick sample.
// Backpressure: none; each frame result is held until the next frame overwrites it.
//
// Ports:
//   i_clk       - system clock, all state on its rising edge
//   i_rst_n     - async active-low reset
//   i_b_tick    - single-cycle strobe at OVS x baud
//   i_rx        - serial line, async to i_clk, idle high
//   o_rx_data   - last received byte, held until the next frame completes
//   o_rx_done   - one-clk pulse per completed frame (good or errored)
//   o_rx_busy   - high from start-bit detection until back in IDLE
//   o_frame_err - stop-bit status of the last frame, valid with o_rx_done
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVS         = OVS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_b_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_done,
  output logic                 o_rx_busy,
  output logic                 o_frame_err
);

  localparam logic [TICK_CNT_W-1:0] TICK_MID = tick_mid(OVS);
  localparam logic [TICK_CNT_W-1:0] TICK_END = tick_end(OVS);
  localparam logic [BIT_CNT_W-1:0]  BIT_LAST = BIT_CNT_W'(DATA_BITS - 1);

  logic w_rx_s;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (w_rx_s)
  );

  uart_state_t           r_state,    w_state_nxt;
  logic [TICK_CNT_W-1:0] r_tick_cnt, w_tick_nxt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt,  w_bit_nxt;
  logic [DATA_BITS-1:0]  r_buf,      w_buf_nxt;
  uart_rx_res_t          r_res,      w_res_nxt;
  logic                  r_done,     w_done_nxt;
  logic                  r_busy,     w_busy_nxt;
  // Cleared by a frame error so a held-low line (break) yields only one
  // errored frame; re-armed once the line is seen idle in IDLE.
  logic                  r_armed,    w_armed_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_buf      <= '0;
      r_res      <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_buf      <= w_buf_nxt;
      r_res      <= w_res_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= w_busy_nxt;
      r_armed    <= w_armed_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_buf_nxt   = r_buf;
    w_res_nxt   = r_res;
    w_done_nxt  = 1'b0;
    w_busy_nxt  = r_busy;
    w_armed_nxt = r_armed;

    unique case (r_state)
      IDLE: begin
        w_busy_nxt = 1'b0;
        if (w_rx_s) begin
          w_armed_nxt = 1'b1;
        end else if (r_armed) begin
          // Falling edge seen: tick phase restarts here so the START
          // check lands near the middle of the start bit.
          w_state_nxt = START;
          w_tick_nxt  = '0;
          w_busy_nxt  = 1'b1;
        end
      end

      START: begin
        if (i_b_tick) begin
          if (r_tick_cnt == TICK_MID) begin
            if (!w_rx_s) begin
              w_state_nxt = DATA;
              w_tick_nxt  = '0;
              w_bit_nxt   = '0;
            end else begin
              // Line went back high before mid start bit: glitch.
              w_state_nxt = IDLE;
              w_busy_nxt  = 1'b0;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end

      DATA: begin
        if (i_b_tick) begin
          if (r_tick_cnt == TICK_END) begin
            // LSB arrives first, so shift in from the top.
            w_buf_nxt  = {w_rx_s, r_buf[DATA_BITS-1:1]};
            w_tick_nxt = '0;
            if (r_bit_cnt == BIT_LAST) begin
              w_state_nxt = STOP;
            end else begin
              w_bit_nxt = r_bit_cnt + 1'b1;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end

      STOP: begin
        if (i_b_tick) begin
          if (r_tick_cnt == TICK_END) begin
            // Leave at mid stop bit; the remaining half bit gives IDLE
            // time to catch a back-to-back start edge.
            w_res_nxt.data      = r_buf;
            w_res_nxt.frame_err = ~w_rx_s;
            w_done_nxt          = 1'b1;
            w_state_nxt         = IDLE;
            w_busy_nxt          = 1'b0;
            w_tick_nxt          = '0;
            if (!w_rx_s) begin
              w_armed_nxt = 1'b0;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign o_rx_data   = r_res.data;
  assign o_frame_err = r_res.frame_err;
  assign o_rx_done   = r_done;
  assign o_rx_busy   = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Purpose: directed bench for uart_rx with a serial sender model and a frame scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx;

  localparam int OVS        = 16;
  localparam int TICK_NOM   = 54;
  localparam int BIT_CLKS   = TICK_NOM * OVS;
  localparam int FRAME_CLKS = BIT_CLKS * 10;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       b_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  int   done_cnt = 0;
  int   e_done = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_err = 1'b0;
  int   tick_div = TICK_NOM;
  int   tick_phase = 0;
  logic prev_tick = 1'b0;
  logic prev_done = 1'b0;

  uart_rx #(
    .OVS         (OVS),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_b_tick    (b_tick),
    .i_rx        (rx),
    .o_rx_data   (rx_data),
    .o_rx_done   (rx_done),
    .o_rx_busy   (rx_busy),
    .o_frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Baud tick source; period is changeable to emulate receiver clock offset.
  initial begin
    b_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_phase >= tick_div - 1) begin
        tick_phase = 0;
        b_tick     = 1'b1;
      end else begin
        tick_phase = tick_phase + 1;
        b_tick     = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every rx_done pops one expected frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && rx_done === 1'b1) begin
        done_cnt++;
        check("done_after_tick", 32'(prev_tick), 32'd1);
        check("done_single_cycle", 32'(prev_done), 32'd0);
        check("done_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.data));
          check("frame_err", 32'(frame_err), 32'(e.err));
          last_data = e.data;
          last_err  = e.err;
        end
      end
      prev_tick = b_tick;
      prev_done = rx_done;
    end
  end

  initial begin
    repeat (140000) @(posedge clk);
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic drive_bit(input logic v);
    @(negedge clk);
    rx = v;
    repeat (BIT_CLKS - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    sb_q.push_back({~stop_v, d});
    e_done++;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_v);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] lb [4];
    logic [7:0] abort_byte;
    lb[0] = 8'h55; lb[1] = 8'hA3; lb[2] = 8'h00; lb[3] = 8'hFF;
    abort_byte = 8'h96;

    // Reset state
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_done", 32'(rx_done), 32'd0);
    check("rst_rx_busy", 32'(rx_busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Back-to-back loopback frames
    for (int i = 0; i < 4; i++) send_frame(lb[i], 1'b1);
    wait_drain(2 * BIT_CLKS);
    check("loopback_done_count", 32'(done_cnt), 32'(e_done));

    // Short low glitch: START must reject it
    @(negedge clk);
    rx = 1'b0;
    repeat (100) @(negedge clk);
    check("glitch_busy_high", 32'(rx_busy), 32'd1);
    repeat (3 * TICK_NOM - 100) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("glitch_busy_low", 32'(rx_busy), 32'd0);
    check("glitch_no_done", 32'(done_cnt), 32'(e_done));
    check("glitch_data_held", 32'(rx_data), 32'(last_data));
    check("glitch_err_held", 32'(frame_err), 32'(last_err));

    // Stop bit low, then break: one errored frame only
    send_frame(8'h3C, 1'b0);
    repeat (3 * FRAME_CLKS) @(negedge clk);
    check("break_single_done", 32'(done_cnt), 32'(e_done));
    check("break_queue_empty", 32'(sb_q.size()), 32'd0);
    check("break_busy_low", 32'(rx_busy), 32'd0);
    check("break_err_held", 32'(frame_err), 32'd1);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("break_release_no_done", 32'(done_cnt), 32'(e_done));

    // Receiver tick 3% fast, then 3% slow
    tick_div = 52;
    repeat (BIT_CLKS) @(negedge clk);
    send_frame(8'hC5, 1'b1);
    wait_drain(2 * BIT_CLKS);
    tick_div = 56;
    repeat (BIT_CLKS) @(negedge clk);
    send_frame(8'hC5, 1'b1);
    wait_drain(2 * BIT_CLKS);
    tick_div = TICK_NOM;
    check("baud_done_count", 32'(done_cnt), 32'(e_done));

    // Reset during data bit 4 of an aborted frame, then a clean frame
    repeat (BIT_CLKS) @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(abort_byte[i]);
    @(negedge clk);
    rx = abort_byte[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy", 32'(rx_busy), 32'd0);
    check("midrst_data", 32'(rx_data), 32'h00);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt), 32'(e_done));
    send_frame(8'h69, 1'b1);
    wait_drain(2 * BIT_CLKS);
    repeat (BIT_CLKS) @(negedge clk);
    check("midrst_done_count", 32'(done_cnt), 32'(e_done));
    check("final_data_held", 32'(rx_data), 32'h69);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVS, default 16, meaning: b_tick pulses per bit period; legal values are 8 or 16.
REQ-002 Parameter SYNC_STAGES, default 2, meaning: flop depth of the rx input synchronizer; minimum 2.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 b_tick  input  1  single-cycle oversampling strobe at OVS times the baud rate, from the shared baud generator.
REQ-006 rx  input  1  serial line, asynchronous to clk; idle high.
REQ-007 rx_data  output  8  last received byte, held until the next frame completes.
REQ-008 rx_done  output  1  one-cycle pulse marking that a frame has completed.
REQ-009 rx_busy  output  1  high from start-bit detection until return to IDLE.
REQ-010 frame_err  output  1  stop-bit status of the last frame; valid from rx_done and held until the next rx_done.

Function
REQ-011 Frame format SHALL be 8N1: start bit low, 8 data bits LSB first, no parity, one stop bit high; this matches the team's transmitter.
REQ-012 All decisions SHALL use rx_s, the output of the SYNC_STAGES synchronizer; raw rx SHALL never reach the FSM.
REQ-013 The FSM SHALL have exactly these states: IDLE, START, DATA, STOP.
REQ-014 Counters: tick_cnt SHALL be 4 bits and advance only on b_tick; bit_cnt SHALL be 3 bits.
REQ-015 IDLE: when armed=1 and rx_s=0, go to START with tick_cnt=0 and rx_busy=1.
REQ-016 START, at the b_tick where tick_cnt==OVS/2-1: if rx_s=0, clear tick_cnt and bit_cnt and go to DATA; if rx_s=1, treat as a false start and return to IDLE with no rx_done.
REQ-017 DATA, at the b_tick where tick_cnt==OVS-1:
- shift buf={rx_s,buf[7:1]} and clear tick_cnt;
- after bit_cnt==7, go to STOP; otherwise increment bit_cnt.
REQ-018 STOP, at the b_tick where tick_cnt==OVS-1 (mid stop bit):
- register rx_data=buf and frame_err=~rx_s;
- pulse rx_done for exactly one clk on the following cycle;
- go to IDLE.
REQ-019 rx_data and frame_err SHALL be updated on every completed frame, including errored frames.
REQ-020 Break handling: armed SHALL clear on a frame error and set again only after rx_s=1 is seen in IDLE, so a line held low produces exactly one errored frame.
REQ-021 Latency: rx_done SHALL rise 1 clk after the stop-sample b_tick; total from the rx falling edge is about 9.5 bit periods plus SYNC_STAGES+1 clks.
REQ-022 Back-to-back frames with zero idle time between stop and start SHALL be received without loss.
REQ-023 Cycles without b_tick SHALL hold all counters; a b_tick on consecutive clks SHALL be counted each cycle.

Reset
REQ-024 On rst_n low, asynchronously:
- state=IDLE, tick_cnt=0, bit_cnt=0, buf=0x00;
- rx_data=0x00, rx_done=0, rx_busy=0, frame_err=0;
- armed=0 and synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no rx_done; after release, armed SHALL require rx_s=1 before a start is accepted.

Structure
REQ-026 A shared package uart_pkg SHALL hold the state typedef (IDLE/START/DATA/STOP), DATA_BITS=8, and the default OVS; the transmitter SHALL be able to reuse it.
REQ-027 The synchronizer SHALL be a separate sub-module uart_sync (parameter STAGES, reset value 1); the FSM and datapath stay in uart_rx.

Verification
REQ-028 Clock and tick setup: clk 100 MHz, b_tick every 54 clks, OVS=16.
REQ-029 Loopback through the team's transmitter, sending 0x55, 0xA3, 0x00, 0xFF back-to-back -> four rx_done pulses, matching rx_data, frame_err=0.
REQ-030 Glitch on rx low for 3 b_ticks then high -> START returns to IDLE; no rx_done; rx_busy deasserts.
REQ-031 Frame 0x3C sent with stop bit forced low -> rx_data=0x3C, frame_err=1; rx held low for 3 more frame times -> no further rx_done until rx returns high.
REQ-032 rst_n pulsed low during data bit 4 of 0x96, then a clean 0x69 sent -> exactly one rx_done, with rx_data=0x69.
REQ-033 Baud offset of ±3% (b_tick period 52 and 56 clks vs. sender 54) on 0xC5 -> correct rx_data with frame_err=0.
